toeplitz_stream: RTL and testbench



---
 rtl/toeplitz_stream.sv | 90 +++++++++
 tb/tb_toeplitz_stream.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toeplitz_stream.sv
// toeplitz_stream: streaming GF(2) Toeplitz extractor, W raw bits per beat, N-bit blocks to L-bit words
module toeplitz_stream #(
    parameter int W = 8,
    parameter int N = 256,
    parameter int L = 128,
    parameter logic [N+L-2:0] SEED_INIT = '1,
    parameter int CW = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N+L-2:0] seed,
    input  logic           seed_load,
    output logic           seed_err,
    output logic [L-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [CW-1:0]  blocks
);
    localparam int S = N + L - 1;
    localparam int NB = N / W;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;

    logic [S-1:0]  r_sreg;
    logic [BW-1:0] r_b;
    logic [L-1:0]  r_acc;
    logic [L-1:0]  r_out;
    logic          r_ov;
    logic          r_err;
    logic [CW-1:0] r_blocks;

    logic          w_beat;
    logic          w_last;
    logic          w_hs;
    logic          w_seed_ok;
    logic [L-1:0]  w_acc_nxt;
    logic [S-1:0]  w_win;

    assign w_last    = r_b == BW'(NB - 1);
    assign in_ready  = !(w_last && r_ov && !out_ready);
    assign w_beat    = in_valid && in_ready;
    assign w_hs      = r_ov && out_ready;
    assign w_seed_ok = seed_load && r_b == '0 && !w_beat;

    assign out_data  = r_out;
    assign out_valid = r_ov;
    assign seed_err  = r_err;
    assign blocks    = r_blocks;

    // fold all W columns of the current beat into the accumulator; column j uses window s[N-1-j +: L]
    always_comb begin
        w_acc_nxt = r_acc;
        w_win     = '0;
        for (int k = 0; k < W; k++) begin
            w_win = r_sreg >> (N - 1 - (int'(r_b) * W + k));
            if (in_data[W-1-k]) w_acc_nxt = w_acc_nxt ^ w_win[L-1:0];
        end
    end

    // block accumulation, output hand-off, seed loading and word counting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg   <= SEED_INIT;
            r_b      <= '0;
            r_acc    <= '0;
            r_out    <= '0;
            r_ov     <= 1'b0;
            r_err    <= 1'b0;
            r_blocks <= '0;
        end else begin
            r_err <= seed_load && !w_seed_ok;
            if (w_seed_ok) r_sreg <= seed;
            if (w_hs) r_blocks <= r_blocks + 1'b1;
            if (w_beat && w_last) begin
                r_out <= w_acc_nxt;
                r_ov  <= 1'b1;
                r_acc <= '0;
                r_b   <= '0;
            end else begin
                if (w_hs) r_ov <= 1'b0;
                if (w_beat) begin
                    r_acc <= w_acc_nxt;
                    r_b   <= r_b + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_toeplitz_stream.sv
// tb_toeplitz_stream: directed small-config vectors plus randomized default-config blocks against a matrix model
module tb_toeplitz_stream;
    localparam int DW = 8;
    localparam int DN = 256;
    localparam int DL = 128;
    localparam int DS = DN + DL - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        s_reset = 1'b1;
    logic [1:0]  s_in_data = '0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [10:0] s_seed = '0;
    logic        s_seed_load = 1'b0;
    logic        s_seed_err;
    logic [3:0]  s_out_data;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [31:0] s_blocks;

    logic          d_reset = 1'b1;
    logic [DW-1:0] d_in_data = '0;
    logic          d_in_valid = 1'b0;
    logic          d_in_ready;
    logic [DS-1:0] d_seed = '0;
    logic          d_seed_load = 1'b0;
    logic          d_seed_err;
    logic [DL-1:0] d_out_data;
    logic          d_out_valid;
    logic          d_out_ready = 1'b1;
    logic [31:0]   d_blocks;

    toeplitz_stream #(.W(2), .N(8), .L(4)) u_small (
        .clk(clk), .reset(s_reset), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .seed(s_seed), .seed_load(s_seed_load), .seed_err(s_seed_err), .out_data(s_out_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .blocks(s_blocks)
    );

    toeplitz_stream u_dut (
        .clk(clk), .reset(d_reset), .in_data(d_in_data), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .seed(d_seed), .seed_load(d_seed_load), .seed_err(d_seed_err), .out_data(d_out_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .blocks(d_blocks)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // q[i] = XOR_j T[i][j] & x[j], T[i][j] = s[i-j+N-1], x[j] = j-th bit in arrival order (MSB first)
    function automatic logic [DL-1:0] golden(input logic [DS-1:0] s, input logic [DN-1:0] x);
        logic [DL-1:0] q = '0;
        for (int i = 0; i < DL; i++)
            for (int j = 0; j < DN; j++)
                q[i] = q[i] ^ (x[DN-1-j] & s[i-j+DN-1]);
        return q;
    endfunction

    function automatic logic [DN-1:0] rnd_blk();
        logic [DN-1:0] v = '0;
        for (int i = 0; i < DN / 32; i++) v = {v[DN-33:0], 32'($urandom)};
        return v;
    endfunction

    function automatic logic [DS-1:0] rnd_seed();
        logic [DS:0] v = '0;
        for (int i = 0; i < 12; i++) v = {v[DS-32:0], 32'($urandom)};
        return v[DS-1:0];
    endfunction

    task automatic sbeat(input logic [1:0] d);
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_data  = d;
        @(posedge clk);
        #1 s_in_valid = 1'b0;
    endtask

    task automatic sblock(input logic [7:0] v);
        for (int b = 0; b < 4; b++) sbeat(v[7-2*b -: 2]);
    endtask

    task automatic dbeat(input logic [DW-1:0] d, input logic sl);
        int t = 0;
        @(negedge clk);
        d_in_valid  = 1'b1;
        d_in_data   = d;
        d_seed_load = sl;
        while (!d_in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("in_ready_timeout", 128'(d_in_ready), 128'(1));
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        d_seed_load = 1'b0;
    endtask

    task automatic dsend(input logic [DN-1:0] blk, input int lo, input int hi);
        for (int b = lo; b <= hi; b++) dbeat(blk[DN-1-DW*b -: DW], 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DS-1:0] m_seed;
        logic [DS-1:0] ns;
        logic [DN-1:0] a;
        logic [DN-1:0] b;
        // small configuration, directed vectors
        repeat (2) @(posedge clk);
        #1;
        check("s_rst_valid", 128'(s_out_valid), 128'(0));
        check("s_rst_data", 128'(s_out_data), 128'(0));
        check("s_rst_ready", 128'(s_in_ready), 128'(1));
        @(negedge clk) s_reset = 1'b0;
        sblock(8'b1011_0000);
        check("s_ones_valid", 128'(s_out_valid), 128'(1));
        check("s_ones_data", 128'(s_out_data), 128'(4'b1111));
        @(posedge clk);
        #1;
        check("s_ones_blocks", 128'(s_blocks), 128'(1));
        check("s_ones_drop", 128'(s_out_valid), 128'(0));
        @(negedge clk);
        s_seed      = 11'h080;
        s_seed_load = 1'b1;
        @(posedge clk);
        #1 s_seed_load = 1'b0;
        check("s_seed_ok", 128'(s_seed_err), 128'(0));
        sblock(8'hA5);
        check("s_id_a5", 128'(s_out_data), 128'(4'b0101));
        sblock(8'hFF);
        check("s_id_ff", 128'(s_out_data), 128'(4'b1111));
        // default configuration: reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(d_out_valid), 128'(0));
        check("rst_data", 128'(d_out_data), 128'(0));
        check("rst_blocks", 128'(d_blocks), 128'(0));
        check("rst_err", 128'(d_seed_err), 128'(0));
        check("rst_ready", 128'(d_in_ready), 128'(1));
        @(negedge clk) d_reset = 1'b0;
        m_seed = '1;
        for (int n = 0; n < 4; n++) begin
            a = rnd_blk();
            dsend(a, 0, 31);
            check("rand_valid", 128'(d_out_valid), 128'(1));
            check("rand_data", 128'(d_out_data), 128'(golden(m_seed, a)));
        end
        @(posedge clk);
        #1;
        check("rand_blocks", 128'(d_blocks), 128'(4));
        check("rand_drop", 128'(d_out_valid), 128'(0));
        // backpressure: second block accumulates while first word is held
        @(negedge clk) d_out_ready = 1'b0;
        a = rnd_blk();
        b = rnd_blk();
        dsend(a, 0, 31);
        check("bp_a_data", 128'(d_out_data), 128'(golden(m_seed, a)));
        dsend(b, 0, 30);
        check("bp_a_stable", 128'(d_out_data), 128'(golden(m_seed, a)));
        @(negedge clk);
        d_in_valid = 1'b1;
        d_in_data  = b[7:0];
        #1 check("bp_ready_low", 128'(d_in_ready), 128'(0));
        @(posedge clk);
        #1;
        check("bp_hold_valid", 128'(d_out_valid), 128'(1));
        check("bp_hold_data", 128'(d_out_data), 128'(golden(m_seed, a)));
        check("bp_hold_blocks", 128'(d_blocks), 128'(4));
        @(negedge clk) d_out_ready = 1'b1;
        #1 check("bp_ready_high", 128'(d_in_ready), 128'(1));
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        check("bp_b_valid", 128'(d_out_valid), 128'(1));
        check("bp_b_data", 128'(d_out_data), 128'(golden(m_seed, b)));
        check("bp_b_blocks", 128'(d_blocks), 128'(5));
        @(posedge clk);
        #1;
        check("bp_end_valid", 128'(d_out_valid), 128'(0));
        check("bp_end_blocks", 128'(d_blocks), 128'(6));
        // seed load rejected mid-block and alongside a beat, accepted when idle at b=0
        ns = rnd_seed();
        d_seed = ns;
        a = rnd_blk();
        dsend(a, 0, 1);
        @(negedge clk) d_seed_load = 1'b1;
        @(posedge clk);
        #1 d_seed_load = 1'b0;
        check("seed_mid_err", 128'(d_seed_err), 128'(1));
        @(posedge clk);
        #1 check("seed_mid_pulse", 128'(d_seed_err), 128'(0));
        dsend(a, 2, 31);
        check("seed_mid_data", 128'(d_out_data), 128'(golden(m_seed, a)));
        b = rnd_blk();
        dbeat(b[DN-1 -: DW], 1'b1);
        check("seed_beat_err", 128'(d_seed_err), 128'(1));
        dsend(b, 1, 31);
        check("seed_beat_data", 128'(d_out_data), 128'(golden(m_seed, b)));
        @(negedge clk) d_seed_load = 1'b1;
        @(posedge clk);
        #1 d_seed_load = 1'b0;
        check("seed_ok_err", 128'(d_seed_err), 128'(0));
        m_seed = ns;
        a = rnd_blk();
        dsend(a, 0, 31);
        check("seed_new_data", 128'(d_out_data), 128'(golden(m_seed, a)));
        // reset with a pending word and a partial block
        @(negedge clk) d_out_ready = 1'b0;
        b = rnd_blk();
        dsend(b, 0, 4);
        check("prerst_valid", 128'(d_out_valid), 128'(1));
        @(negedge clk) d_reset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_valid", 128'(d_out_valid), 128'(0));
        check("mrst_data", 128'(d_out_data), 128'(0));
        check("mrst_blocks", 128'(d_blocks), 128'(0));
        check("mrst_err", 128'(d_seed_err), 128'(0));
        check("mrst_ready", 128'(d_in_ready), 128'(1));
        @(negedge clk);
        d_reset     = 1'b0;
        d_out_ready = 1'b1;
        m_seed      = '1;
        a = rnd_blk();
        dsend(a, 0, 31);
        check("post_rst_data", 128'(d_out_data), 128'(golden(m_seed, a)));
        @(posedge clk);
        #1 check("post_rst_blocks", 128'(d_blocks), 128'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
